// File: rtl/systolic_result_collector.sv
// Deskews the row-staggered partial-sum bus, requantizes each row (>>> SHIFT, saturate) and queues whole vectors.
// res_valid to out_valid is N+1 cycles; a full FIFO with no pop drops the vector and sets sticky overflow.
module systolic_result_collector #(
  parameter int PARTIAL_SUM_BW = 20,
  parameter int NUM_PE_ROWS    = 8,
  parameter int OUT_BW         = 8,
  parameter int SHIFT          = 6,
  parameter int FIFO_DEPTH     = 4,
  parameter int FRAME_LEN      = 8
) (
  input  logic                                      clk,
  input  logic                                      rstn,
  input  logic                                      res_valid,
  input  logic [NUM_PE_ROWS*PARTIAL_SUM_BW-1:0]     result,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [NUM_PE_ROWS*OUT_BW-1:0]             out_data,
  output logic                                      out_last,
  output logic                                      overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]           fifo_count
);

  localparam int N   = NUM_PE_ROWS;
  localparam int PSB = PARTIAL_SUM_BW;
  localparam int VW  = N * OUT_BW;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BCW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  localparam logic signed [PSB-1:0] QMAX = PSB'((1 << (OUT_BW - 1)) - 1);
  localparam logic signed [PSB-1:0] QMIN = ~QMAX;

  function automatic logic [OUT_BW-1:0] requant(input logic signed [PSB-1:0] x);
    logic signed [PSB-1:0] y;
    y = x >>> SHIFT;
    if (y > QMAX)      return QMAX[OUT_BW-1:0];
    else if (y < QMIN) return QMIN[OUT_BW-1:0];
    else               return y[OUT_BW-1:0];
  endfunction

  // Row i waits N-1-i cycles so every row lines up with the last row.
  logic signed [PSB-1:0] aligned [N];

  for (genvar i = 0; i < N; i++) begin : g_deskew
    if (i == N - 1) begin : g_direct
      assign aligned[i] = result[(i+1)*PSB-1 -: PSB];
    end else begin : g_chain
      localparam int D = N - 1 - i;
      logic [PSB-1:0] chain_q [D];
      always_ff @(posedge clk) begin
        chain_q[0] <= result[(i+1)*PSB-1 -: PSB];
        for (int k = 1; k < D; k++) chain_q[k] <= chain_q[k-1];
      end
      assign aligned[i] = chain_q[D-1];
    end
  end

  logic [N-2:0] vld_q;
  logic         qv_q;
  logic [VW-1:0] q_dat_q;
  logic [VW-1:0] q_dat_d;

  always_comb begin
    q_dat_d = '0;
    for (int i = 0; i < N; i++) q_dat_d[i*OUT_BW +: OUT_BW] = requant(aligned[i]);
  end

  always_ff @(posedge clk) begin
    q_dat_q <= q_dat_d;
    if (!rstn) begin
      vld_q <= '0;
      qv_q  <= 1'b0;
    end else begin
      vld_q <= {vld_q[N-3:0], res_valid};
      qv_q  <= vld_q[N-2];
    end
  end

  logic [VW-1:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_q, rd_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [BCW-1:0] beat_q, beat_d;
  logic           ovf_q, ovf_d;
  logic           full, pop, wr_en;

  assign full  = (cnt_q == CW'(FIFO_DEPTH));
  assign pop   = out_valid && out_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign wr_en = qv_q && (!full || pop);

  always_comb begin
    cnt_d  = cnt_q;
    if (wr_en && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!wr_en && pop) cnt_d = cnt_q - 1'b1;
    ovf_d  = ovf_q | (qv_q && full && !pop);
    beat_d = beat_q;
    if (pop) beat_d = (beat_q == BCW'(FRAME_LEN - 1)) ? '0 : beat_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= q_dat_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      beat_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (pop)   rd_q <= rd_q + 1'b1;
      cnt_q  <= cnt_d;
      beat_q <= beat_d;
      ovf_q  <= ovf_d;
    end
  end

  // Head is masked when empty so the un-reset storage never leaks out.
  assign out_valid  = (cnt_q != '0);
  assign out_data   = out_valid ? mem_q[rd_q] : '0;
  assign out_last   = out_valid && (beat_q == BCW'(FRAME_LEN - 1));
  assign overflow   = ovf_q;
  assign fifo_count = cnt_q;

endmodule

// File: tb/tb_systolic_result_collector.sv
// Directed bench for systolic_result_collector: staggered stimulus, cycle-exact checks at the falling edge.
module tb_systolic_result_collector;
  localparam int N   = 8;
  localparam int PSB = 20;
  localparam int OB  = 8;

  logic              clk = 1'b0;
  logic              rstn;
  logic              res_valid;
  logic [N*PSB-1:0]  result;
  logic              out_valid;
  logic              out_ready;
  logic [N*OB-1:0]   out_data;
  logic              out_last;
  logic              overflow;
  logic [2:0]        fifo_count;

  int tests_run = 0;
  int tests_failed = 0;

  logic signed [PSB-1:0] stim  [16][N];
  logic signed [OB-1:0]  exp_v [16][N];

  always #5 clk = ~clk;

  systolic_result_collector dut (
    .clk(clk), .rstn(rstn), .res_valid(res_valid), .result(result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .overflow(overflow), .fifo_count(fifo_count)
  );

  task automatic do_reset();
    rstn = 1'b0; res_valid = 1'b0; out_ready = 1'b0; result = '0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  // Vectors 0..n-1 issued back-to-back from cycle 0; row i of vector v is on the bus in cycle v+i.
  task automatic drive_cycle(input int c, input int n);
    int idx;
    res_valid = (c >= 0 && c < n);
    for (int i = 0; i < N; i++) begin
      idx = c - i;
      result[(i+1)*PSB-1 -: PSB] = (idx >= 0 && idx < n) ? stim[idx][i] : '0;
    end
  endtask

  function automatic logic [N*OB-1:0] exp_vec(input int idx);
    logic [N*OB-1:0] e;
    for (int i = 0; i < N; i++) e[i*OB +: OB] = exp_v[idx][i];
    return e;
  endfunction

  task automatic test_reset();
    rstn = 1'b0; res_valid = 1'b1; out_ready = 1'b1; result = '1;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({out_valid, out_last, overflow} !== 3'b000 || fifo_count !== 3'd0 || out_data !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got vld=%b last=%b ovf=%b cnt=%0d data=%h, want all 0",
               out_valid, out_last, overflow, fifo_count, out_data);
    end
    do_reset();
  endtask

  task automatic test_single();
    for (int i = 0; i < N; i++) begin stim[0][i] = 20'sd640; exp_v[0][i] = 8'sd10; end
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      drive_cycle(c, 1);
      @(negedge clk);
      if (c == 8) begin
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL single_early: out_valid=%b in cycle 8, want 0", out_valid); end
      end
      if (c == 9) begin
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== exp_vec(0) || out_last !== 1'b0) begin
          tests_failed++;
          $display("FAIL single_data: vld=%b data=%h last=%b, want vld=1 data=%h last=0", out_valid, out_data, out_last, exp_vec(0));
        end
      end
      if (c == 10) begin
        tests_run++;
        if (fifo_count !== 3'd0 || out_valid !== 1'b0) begin
          tests_failed++; $display("FAIL single_drain: cnt=%0d vld=%b, want 0 0", fifo_count, out_valid);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rounding();
    stim[0]  = '{20'sd100000, -20'sd100000, -20'sd1, 20'sd63, 20'sd64, -20'sd65, 20'sd8191, 20'sd0};
    exp_v[0] = '{8'sd127, -8'sd128, -8'sd1, 8'sd0, 8'sd1, -8'sd2, 8'sd127, 8'sd0};
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c <= 9; c++) begin
      drive_cycle(c, 1);
      @(negedge clk);
      if (c == 9) begin
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== exp_vec(0)) begin
          tests_failed++; $display("FAIL rounding: vld=%b data=%h, want vld=1 data=%h", out_valid, out_data, exp_vec(0));
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic load_five();
    for (int k = 0; k < 5; k++)
      for (int i = 0; i < N; i++) begin stim[k][i] = PSB'((k + 1) * 64); exp_v[k][i] = OB'(k + 1); end
  endtask

  task automatic test_overflow();
    int got;
    load_five();
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c <= 13; c++) begin
      drive_cycle(c, 5);
      @(negedge clk);
      if (c == 12) begin
        tests_run++;
        if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
          tests_failed++; $display("FAIL ovf_full: cnt=%0d ovf=%b, want 4 0", fifo_count, overflow);
        end
      end
      if (c == 13) begin
        tests_run++;
        if (fifo_count !== 3'd4 || overflow !== 1'b1) begin
          tests_failed++; $display("FAIL ovf_set: cnt=%0d ovf=%b, want 4 1", fifo_count, overflow);
        end
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        tests_run++;
        if (got >= 4 || out_data !== exp_vec(got)) begin
          tests_failed++; $display("FAIL ovf_drain_%0d: data=%h, want %h", got, out_data, exp_vec(got < 4 ? got : 0));
        end
        got++;
      end
      @(posedge clk); #1;
    end
    tests_run++;
    if (got != 4 || overflow !== 1'b1) begin
      tests_failed++; $display("FAIL ovf_drain_count: beats=%0d ovf=%b, want 4 1", got, overflow);
    end
    do_reset();
    @(negedge clk);
    tests_run++;
    if (overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_clear: ovf=%b after reset, want 0", overflow); end
    @(posedge clk); #1;
  endtask

  task automatic test_full_pop();
    int got;
    load_five();
    do_reset();
    for (int c = 0; c <= 13; c++) begin
      drive_cycle(c, 5);
      out_ready = (c == 12);
      @(negedge clk);
      if (c == 12) begin
        tests_run++;
        if (fifo_count !== 3'd4 || out_data !== exp_vec(0)) begin
          tests_failed++; $display("FAIL fullpop_head: cnt=%0d data=%h, want 4 %h", fifo_count, out_data, exp_vec(0));
        end
      end
      if (c == 13) begin
        tests_run++;
        if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
          tests_failed++; $display("FAIL fullpop_count: cnt=%0d ovf=%b, want 4 0", fifo_count, overflow);
        end
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    got = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        tests_run++;
        if (got >= 5 || out_data !== exp_vec(got)) begin
          tests_failed++; $display("FAIL fullpop_drain_%0d: data=%h, want %h", got, out_data, exp_vec(got < 5 ? got : 0));
        end
        got++;
      end
      @(posedge clk); #1;
    end
    tests_run++;
    if (got != 5) begin tests_failed++; $display("FAIL fullpop_lost: drained %0d, want 4", got - 1); end
  endtask

  task automatic test_back_to_back();
    int beats, lasts;
    for (int k = 0; k < 16; k++)
      for (int i = 0; i < N; i++) begin stim[k][i] = PSB'((k + 1 + i) * 64); exp_v[k][i] = OB'(k + 1 + i); end
    do_reset();
    out_ready = 1'b1;
    beats = 0; lasts = 0;
    for (int c = 0; c <= 40; c++) begin
      drive_cycle(c, 16);
      @(negedge clk);
      if (out_valid === 1'b1) begin
        tests_run++;
        if (beats >= 16 || out_data !== exp_vec(beats < 16 ? beats : 0) || out_last !== ((beats % 8) == 7)) begin
          tests_failed++;
          $display("FAIL frame_beat_%0d: data=%h last=%b, want %h last=%b", beats + 1, out_data, out_last,
                   exp_vec(beats < 16 ? beats : 0), ((beats % 8) == 7));
        end
        if (out_last === 1'b1) lasts++;
        beats++;
      end
      if (c == 10) begin
        tests_run++;
        if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL frame_stream: out_valid=%b mid-stream, want 1", out_valid); end
      end
      @(posedge clk); #1;
    end
    tests_run++;
    if (beats != 16 || lasts != 2) begin
      tests_failed++; $display("FAIL frame_totals: beats=%0d lasts=%0d, want 16 2", beats, lasts);
    end
  endtask

  task automatic test_reset_midop();
    int seen;
    for (int i = 0; i < N; i++) stim[0][i] = 20'sd640;
    do_reset();
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c <= 20; c++) begin
      drive_cycle(c, 1);
      rstn = (c != 3);
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
      if (c == 4) begin
        tests_run++;
        if ({out_valid, out_last, overflow} !== 3'b000 || fifo_count !== 3'd0 || out_data !== '0) begin
          tests_failed++;
          $display("FAIL midop_outputs: vld=%b last=%b ovf=%b cnt=%0d data=%h, want all 0",
                   out_valid, out_last, overflow, fifo_count, out_data);
        end
      end
      @(posedge clk); #1;
    end
    tests_run++;
    if (seen != 0) begin tests_failed++; $display("FAIL midop_valid: out_valid seen %0d cycles, want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rounding();
    test_overflow();
    test_full_pop();
    test_back_to_back();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
